uart_param_duplex: RTL and testbench

Parametrised full-duplex UART: a run-time programmable baud tick, 16x oversampled receiver, configurable word length, parity and stop bits, and an edge-triggered transmit request. It replaces the fixed-rate PLL/clock-divider and external one-shot arrangement. The whole block runs on the system clock and sits between board-level serial pins and the user datapath. It adds framing and overrun detection to the existing parity check.

---
 rtl/uart_param_duplex_pkg.sv | 41 ++++
 rtl/uart_param_duplex_if.sv | 34 +++
 rtl/uart_param_duplex_baud_tick.sv | 29 ++
 rtl/uart_param_duplex.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_param_duplex.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_param_duplex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM encodings and parity helper for the UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_EVEN   = 1;
    localparam int PAR_ODD    = 2;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Parity bit to send (or expect) given the XOR of the data bits.
    function automatic logic parity_bit(input logic xor_in, input int mode);
        if (mode == PAR_EVEN)
            return xor_in;
        else if (mode == PAR_ODD)
            return ~xor_in;
        else
            return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_param_duplex_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_param_duplex_if
// Description : Serial pins, user datapath and status bundle of the UART.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_param_duplex_if #(
    parameter int WORD_LENGTH = 8,
    parameter int DIV_WIDTH   = 16
);
    logic [DIV_WIDTH-1:0]   baud_div;
    logic                   SerialDataIn;
    logic [WORD_LENGTH-1:0] DATATX;
    logic                   Transmit;
    logic                   Clear_RX_Flag;
    logic                   SerialDataOut;
    logic                   TX_BUSY;
    logic [WORD_LENGTH-1:0] DATARX;
    logic                   RX_FLAG;
    logic                   ParityError;
    logic                   FramingError;
    logic                   Overrun;

    modport master (
        output baud_div, SerialDataIn, DATATX, Transmit, Clear_RX_Flag,
        input  SerialDataOut, TX_BUSY, DATARX, RX_FLAG, ParityError, FramingError, Overrun
    );

    modport slave (
        input  baud_div, SerialDataIn, DATATX, Transmit, Clear_RX_Flag,
        output SerialDataOut, TX_BUSY, DATARX, RX_FLAG, ParityError, FramingError, Overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_param_duplex_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running oversample tick, one pulse every baud_div+1 clks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [DIV_WIDTH-1:0] i_baud_div,
    output logic                      o_tick
);
    logic [DIV_WIDTH-1:0] r_count;

    // The divisor is only looked at on reload, so a change never truncates a period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (r_count == '0)
            r_count <= i_baud_div;
        else
            r_count <= r_count - 1'b1;
    end

    assign o_tick = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/uart_param_duplex.sv
`default_nettype none
// ============================================================================
// Module      : uart_param_duplex
// Description : Full-duplex UART with programmable baud tick, 16x RX sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_param_duplex
    import uart_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int DIV_WIDTH   = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    uart_param_duplex_if.slave bus
);
    localparam logic [3:0] c_last_tick = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_mid_tick  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] c_last_data = 5'(WORD_LENGTH - 1);
    localparam logic [4:0] c_last_stop = 5'(STOP_BITS - 1);

    logic w_tick;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
        .clk        (clk),
        .reset      (reset),
        .i_baud_div (bus.baud_div),
        .o_tick     (w_tick)
    );

    // ------------------------------------------------------------------ TX
    tx_state_t              r_tx_state, w_tx_state_nxt;
    logic [3:0]             r_tx_tick, w_tx_tick_nxt;
    logic [4:0]             r_tx_bit, w_tx_bit_nxt;
    logic [WORD_LENGTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                   r_tx_par, w_tx_par_nxt;
    logic                   r_sdo, w_sdo_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_transmit_q, r_transmit_qq;
    logic                   w_tx_rise, w_tx_bit_done;

    assign w_tx_rise     = r_transmit_q & ~r_transmit_qq;
    assign w_tx_bit_done = w_tick && (r_tx_tick == c_last_tick);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_tick_nxt  = r_tx_tick;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_sdo_nxt      = r_sdo;
        w_busy_nxt     = r_busy;
        if (r_tx_state != TX_IDLE && w_tick)
            w_tx_tick_nxt = r_tx_tick + 1'b1;
        unique case (r_tx_state)
            TX_IDLE: begin
                // Requests arriving while busy never reach here, so they are dropped.
                if (w_tx_rise) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = bus.DATATX;
                    w_tx_par_nxt   = parity_bit(^bus.DATATX, PARITY_MODE);
                    w_tx_tick_nxt  = '0;
                    w_sdo_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_bit_done) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_bit_nxt   = '0;
                    w_sdo_nxt      = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_bit_done) begin
                    if (r_tx_bit == c_last_data) begin
                        w_tx_bit_nxt = '0;
                        if (PARITY_MODE != PAR_NONE) begin
                            w_tx_state_nxt = TX_PARITY;
                            w_sdo_nxt      = r_tx_par;
                        end else begin
                            w_tx_state_nxt = TX_STOP;
                            w_sdo_nxt      = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 1'b1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[WORD_LENGTH-1:1]};
                        w_sdo_nxt      = r_tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_bit_done) begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_bit_nxt   = '0;
                    w_sdo_nxt      = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_done) begin
                    if (r_tx_bit == c_last_stop) begin
                        w_tx_state_nxt = TX_IDLE;
                        w_busy_nxt     = 1'b0;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 1'b1;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state    <= TX_IDLE;
            r_tx_tick     <= '0;
            r_tx_bit      <= '0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_sdo         <= 1'b1;
            r_busy        <= 1'b0;
            r_transmit_q  <= 1'b0;
            r_transmit_qq <= 1'b0;
        end else begin
            r_tx_state    <= w_tx_state_nxt;
            r_tx_tick     <= w_tx_tick_nxt;
            r_tx_bit      <= w_tx_bit_nxt;
            r_tx_shift    <= w_tx_shift_nxt;
            r_tx_par      <= w_tx_par_nxt;
            r_sdo         <= w_sdo_nxt;
            r_busy        <= w_busy_nxt;
            r_transmit_q  <= bus.Transmit;
            r_transmit_qq <= r_transmit_q;
        end
    end

    // ------------------------------------------------------------------ RX
    rx_state_t              r_rx_state, w_rx_state_nxt;
    logic [3:0]             r_rx_tick, w_rx_tick_nxt;
    logic [4:0]             r_rx_bit, w_rx_bit_nxt;
    logic [WORD_LENGTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                   r_rx_perr, w_rx_perr_nxt;
    logic                   r_rx_sync1, r_rx_sync2, r_rx_prev;
    logic [WORD_LENGTH-1:0] r_datarx, w_datarx_nxt;
    logic                   r_flag, w_flag_nxt;
    logic                   r_par_err, w_par_err_nxt;
    logic                   r_frm_err, w_frm_err_nxt;
    logic                   r_overrun, w_overrun_nxt;
    logic                   w_rx_fall, w_rx_sample;

    assign w_rx_fall   = r_rx_prev & ~r_rx_sync2;
    assign w_rx_sample = w_tick &&
                         (r_rx_tick == ((r_rx_state == RX_START) ? c_mid_tick : c_last_tick));

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_tick_nxt  = r_rx_tick;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_perr_nxt  = r_rx_perr;
        w_datarx_nxt   = r_datarx;
        w_flag_nxt     = r_flag;
        w_par_err_nxt  = r_par_err;
        w_frm_err_nxt  = r_frm_err;
        w_overrun_nxt  = r_overrun;
        if (bus.Clear_RX_Flag) begin
            w_flag_nxt    = 1'b0;
            w_par_err_nxt = 1'b0;
            w_frm_err_nxt = 1'b0;
            w_overrun_nxt = 1'b0;
        end
        if (r_rx_state != RX_IDLE && w_tick)
            w_rx_tick_nxt = r_rx_tick + 1'b1;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_tick_nxt  = '0;
                end
            end
            RX_START: begin
                if (w_rx_sample) begin
                    if (r_rx_sync2) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_tick_nxt  = '0;
                        w_rx_bit_nxt   = '0;
                        w_rx_perr_nxt  = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_sample) begin
                    w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[WORD_LENGTH-1:1]};
                    if (r_rx_bit == c_last_data)
                        w_rx_state_nxt = (PARITY_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
                    else
                        w_rx_bit_nxt = r_rx_bit + 1'b1;
                end
            end
            RX_PARITY: begin
                if (w_rx_sample) begin
                    w_rx_state_nxt = RX_STOP;
                    w_rx_perr_nxt  = r_rx_sync2 != parity_bit(^r_rx_shift, PARITY_MODE);
                end
            end
            RX_STOP: begin
                // Completion overrides a coincident clear, but then Overrun is not raised.
                if (w_rx_sample) begin
                    w_rx_state_nxt = RX_IDLE;
                    w_datarx_nxt   = r_rx_shift;
                    w_par_err_nxt  = r_rx_perr;
                    w_frm_err_nxt  = ~r_rx_sync2;
                    w_overrun_nxt  = bus.Clear_RX_Flag ? 1'b0 : (r_overrun | r_flag);
                    w_flag_nxt     = 1'b1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_datarx   <= '0;
            r_flag     <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_tick  <= w_rx_tick_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_perr  <= w_rx_perr_nxt;
            r_rx_sync1 <= bus.SerialDataIn;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            r_datarx   <= w_datarx_nxt;
            r_flag     <= w_flag_nxt;
            r_par_err  <= w_par_err_nxt;
            r_frm_err  <= w_frm_err_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign bus.SerialDataOut = r_sdo;
    assign bus.TX_BUSY       = r_busy;
    assign bus.DATARX        = r_datarx;
    assign bus.RX_FLAG       = r_flag;
    assign bus.ParityError   = r_par_err;
    assign bus.FramingError  = r_frm_err;
    assign bus.Overrun       = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_param_duplex.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_param_duplex
// Description : Scoreboard bench for uart_param_duplex (8 bits, even parity, D=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_param_duplex;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } rx_exp_t;

    logic clk = 1'b0;
    logic reset;
    logic loop_en;
    logic inj_line;
    logic tx_mon_en;
    int   cyc;
    int   total = 0;
    int   bad = 0;
    int   tx_frames = 0;

    rx_exp_t      rxq[$];
    logic [10:0]  txq[$];
    logic [10:0]  tx_got;
    logic [11:0]  rx_prev;
    logic [11:0]  rx_snap;

    uart_param_duplex_if #(.WORD_LENGTH(8), .DIV_WIDTH(16)) bus ();

    uart_param_duplex #(
        .WORD_LENGTH (8),
        .PARITY_MODE (1),
        .STOP_BITS   (1),
        .DIV_WIDTH   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.SerialDataIn = loop_en ? bus.SerialDataOut : inj_line;

    always #5 clk = ~clk;

    // At a falling edge, cyc is the index of the next rising edge since reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // RX monitor: any change of the receive outputs with RX_FLAG high is a completion.
    initial begin
        rx_prev = '0;
        forever begin
            @(negedge clk);
            rx_snap = {bus.DATARX, bus.ParityError, bus.FramingError, bus.Overrun, bus.RX_FLAG};
            if (!reset && rx_snap != rx_prev && bus.RX_FLAG) begin
                if (rxq.size() == 0) begin
                    check("rx_unexpected_word", {24'd0, bus.DATARX}, 32'hFFFF_FFFF);
                end else begin
                    rx_exp_t e;
                    e = rxq.pop_front();
                    check("rx_data", {24'd0, bus.DATARX}, {24'd0, e.d});
                    check("rx_flags", {28'd0, bus.RX_FLAG, bus.ParityError, bus.FramingError, bus.Overrun},
                          {28'd0, 1'b1, e.pe, e.fe, e.ov});
                end
            end
            rx_prev = rx_snap;
        end
    end

    // TX monitor: sample each bit near its centre, 64 clks per bit at baud_div=3.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_mon_en && !reset && bus.SerialDataOut == 1'b0) begin
                repeat (30) @(negedge clk);
                tx_got[0] = bus.SerialDataOut;
                for (int k = 1; k < 11; k++) begin
                    repeat (64) @(negedge clk);
                    tx_got[k] = bus.SerialDataOut;
                end
                tx_frames++;
                if (txq.size() == 0)
                    check("tx_unexpected_frame", {21'd0, tx_got}, 32'hFFFF_FFFF);
                else
                    check("tx_frame", {21'd0, tx_got}, {21'd0, txq.pop_front()});
            end
        end
    end

    // Drive one frame on the injected line; optionally hold Clear_RX_Flag around the stop sample.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stopv, input logic coinc);
        logic [10:0] bits;
        int a, n1, pc;
        bits = {stopv, (^d) ^ flip, d, 1'b0};
        @(negedge clk);
        a  = cyc;
        n1 = ((a + 6) / 4) * 4;
        pc = n1 + 668;
        for (int i = 0; i < 768; i++) begin
            inj_line = (i < 704) ? bits[i / 64] : 1'b1;
            if (coinc) bus.Clear_RX_Flag = (cyc >= pc - 2) && (cyc <= pc);
            @(negedge clk);
        end
        bus.Clear_RX_Flag = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.Clear_RX_Flag = 1'b1;
        @(negedge clk);
        bus.Clear_RX_Flag = 1'b0;
    endtask

    initial begin
        int  busy_cnt;
        bit  done;
        reset             = 1'b1;
        loop_en           = 1'b0;
        inj_line          = 1'b1;
        tx_mon_en         = 1'b1;
        bus.baud_div      = 16'd3;
        bus.DATATX        = 8'h00;
        bus.Transmit      = 1'b0;
        bus.Clear_RX_Flag = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_sdo_busy", {30'd0, bus.SerialDataOut, bus.TX_BUSY}, 32'h2);
        check("reset_rx_outputs", {20'd0, bus.DATARX, bus.RX_FLAG, bus.ParityError, bus.FramingError, bus.Overrun}, 32'h0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("idle_sdo_busy", {30'd0, bus.SerialDataOut, bus.TX_BUSY}, 32'h2);
        check("idle_flags", {28'd0, bus.RX_FLAG, bus.ParityError, bus.FramingError, bus.Overrun}, 32'h0);

        // Loopback A5 with a second request 10 clks later that must be ignored.
        loop_en = 1'b1;
        txq.push_back({1'b1, 1'b0, 8'hA5, 1'b0});
        rxq.push_back({8'hA5, 1'b0, 1'b0, 1'b0});
        bus.DATATX   = 8'hA5;
        bus.Transmit = 1'b1;
        busy_cnt = 0;
        done     = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (i == 4) bus.Transmit = 1'b0;
            if (i == 9) begin
                check("tx_busy_during_frame", {31'd0, bus.TX_BUSY}, 32'h1);
                bus.DATATX   = 8'hFF;
                bus.Transmit = 1'b1;
            end
            if (bus.TX_BUSY) busy_cnt++;
            else if (busy_cnt > 0) done = 1'b1;
        end
        check("tx_busy_fell", {31'd0, done}, 32'h1);
        total++;
        if (busy_cnt < 701 || busy_cnt > 704) begin
            bad++;
            $display("FAIL tx_frame_length: got=%0d clks expected=701..704", busy_cnt);
        end
        repeat (200) @(negedge clk);
        check("tx_frame_count", tx_frames, 32'd1);
        check("loop_rx_queue_empty", rxq.size(), 32'd0);
        bus.Transmit = 1'b0;
        pulse_clear();
        @(negedge clk);
        check("flag_after_clear", {31'd0, bus.RX_FLAG}, 32'h0);
        loop_en = 1'b0;

        // Parity error, then framing error.
        rxq.push_back({8'h3C, 1'b1, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        pulse_clear();
        rxq.push_back({8'h5A, 1'b0, 1'b1, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        pulse_clear();

        // Overrun, then a completion coincident with Clear_RX_Flag.
        rxq.push_back({8'h11, 1'b0, 1'b0, 1'b0});
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        rxq.push_back({8'h22, 1'b0, 1'b0, 1'b1});
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        rxq.push_back({8'h33, 1'b0, 1'b0, 1'b0});
        send_frame(8'h33, 1'b0, 1'b1, 1'b1);
        check("coincident_flag_ovr", {30'd0, bus.RX_FLAG, bus.Overrun}, 32'h2);
        pulse_clear();

        // Short low glitch on the idle line is a false start.
        @(negedge clk);
        inj_line = 1'b0;
        repeat (12) @(negedge clk);
        inj_line = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_flag", {31'd0, bus.RX_FLAG}, 32'h0);
        check("rx_queue_drained", rxq.size(), 32'd0);
        check("tx_queue_drained", txq.size(), 32'd0);

        // Reset in the middle of data bit 4 of 0x0F (a 0 bit).
        tx_mon_en    = 1'b0;
        bus.DATATX   = 8'h0F;
        bus.Transmit = 1'b1;
        repeat (354) @(negedge clk);
        check("mid_tx_bit4", {30'd0, bus.SerialDataOut, bus.TX_BUSY}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset_abort_tx", {30'd0, bus.SerialDataOut, bus.TX_BUSY}, 32'h2);
        check("reset_abort_rx", {20'd0, bus.DATARX, bus.RX_FLAG, bus.ParityError, bus.FramingError, bus.Overrun}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
